// File: rtl/dmem_pkg.sv
// Shared defaults, FSM encoding and control-pin levels for the data-memory responder.
// No logic; no latency.
// No flow control.
package dmem_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 7;
    localparam int DEPTH_DEF = 128;
    localparam int CW_DEF    = 16;

    typedef enum logic {
        CLEAR  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Asserted levels of the CPU-side control pins
    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_WR = 1'b0;
    localparam logic OEN_ON = 1'b0;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DW word storage, one synchronous write port and one asynchronous read port.
// Write commits at posedge; read is combinational (same-cycle).
// No backpressure; every write strobe is taken.
module dmem_array #(
    parameter int DW    = 32,
    parameter int AW    = 7,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [0:DEPTH-1];

    // No reset: contents are zeroed by the owner's clear sequence
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for a single-cycle CPU: word array, post-reset self-clear, access counters.
// Reads combinational in-cycle, writes at posedge; clear takes DEPTH cycles after reset.
// No backpressure; accesses before ready are dropped, ready stays high until reset.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          ready,
    output logic [CW-1:0] rd_count,
    output logic [CW-1:0] wr_count,
    output logic          oob_err
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;

    logic          cpu_sel;
    logic          in_range;
    logic          rd_vld;
    logic          wr_vld;
    logic          oob_hit;
    logic          q_en;

    logic          arr_we;
    logic [AW-1:0] arr_wa;
    logic [DW-1:0] arr_wd;
    logic [DW-1:0] arr_rd;

    // if-style decode so an unknown CEN/OEN falls to the inactive branch
    always_comb begin
        cpu_sel = 1'b0;
        if (state_q == ACTIVE && CEN == CEN_ON) begin
            cpu_sel = 1'b1;
        end
        in_range = ({1'b0, A} < DEPTH_W);
        rd_vld   = cpu_sel && in_range && (WEN != WEN_WR);
        wr_vld   = cpu_sel && in_range && (WEN == WEN_WR);
        oob_hit  = cpu_sel && !in_range;
        q_en     = 1'b0;
        if (rd_vld && OEN == OEN_ON) begin
            q_en = 1'b1;
        end
    end

    // Next state and write-port mux: clear owns the port until ACTIVE
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        arr_we    = wr_vld;
        arr_wa    = A;
        arr_wd    = D;
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_wa    = clr_ptr_q;
            arr_wd    = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
                state_d = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            oob_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            if (rd_vld && rd_count != CNT_MAX) begin
                rd_count <= rd_count + 1'b1;
            end
            if (wr_vld && wr_count != CNT_MAX) begin
                wr_count <= wr_count + 1'b1;
            end
            if (oob_hit) begin
                oob_err <= 1'b1;
            end
        end
    end

    dmem_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_vld  (arr_we),
        .wr_addr (arr_wa),
        .wr_dat  (arr_wd),
        .rd_addr (A),
        .rd_dat  (arr_rd)
    );

    assign Q     = q_en ? arr_rd : '0;
    assign ready = (state_q == ACTIVE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: default instance plus a DEPTH=100/CW=4 instance on shared stimulus.
// Both checked every cycle against an abstract memory/counter model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] D;

    logic [31:0] q0, q1;
    logic        rdy0, rdy1, oob0, oob1;
    logic [15:0] rc0, wc0;
    logic [3:0]  rc1, wc1;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.DW(32), .AW(7), .DEPTH(128), .CW(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
        .Q(q0), .ready(rdy0), .rd_count(rc0), .wr_count(wc0), .oob_err(oob0)
    );

    data_mem_responder #(.DW(32), .AW(7), .DEPTH(100), .CW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
        .Q(q1), .ready(rdy1), .rd_count(rc1), .wr_count(wc1), .oob_err(oob1)
    );

    always #5 clk = ~clk;

    // Reference model: per instance, a plain array, a clear countdown and counters
    int          m_depth [2] = '{128, 100};
    int          m_cap   [2] = '{65535, 15};
    logic [31:0] m_mem   [2][128];
    int          m_rd    [2];
    int          m_wr    [2];
    int          m_clr   [2];
    bit          m_oob   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] m_q(input int i);
        if (m_clr[i] == 0 && CEN == 1'b0 && WEN == 1'b1 && OEN == 1'b0 && int'(A) < m_depth[i])
            return m_mem[i][A];
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_rd[i]  = 0;
            m_wr[i]  = 0;
            m_oob[i] = 1'b0;
            m_clr[i] = m_depth[i];
            for (int a = 0; a < 128; a++) m_mem[i][a] = 32'd0;
        end
    endtask

    task automatic m_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_clr[i] > 0) begin
                m_clr[i]--;
            end else if (CEN == 1'b0) begin
                if (int'(A) < m_depth[i]) begin
                    if (WEN == 1'b0) begin
                        m_mem[i][A] = D;
                        if (m_wr[i] < m_cap[i]) m_wr[i]++;
                    end else if (m_rd[i] < m_cap[i]) begin
                        m_rd[i]++;
                    end
                end else begin
                    m_oob[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("ready0", {31'd0, rdy0}, {31'd0, m_clr[0] == 0});
        chk("ready1", {31'd0, rdy1}, {31'd0, m_clr[1] == 0});
        chk("rd_count0", {16'd0, rc0}, 32'(m_rd[0]));
        chk("wr_count0", {16'd0, wc0}, 32'(m_wr[0]));
        chk("rd_count1", {28'd0, rc1}, 32'(m_rd[1]));
        chk("wr_count1", {28'd0, wc1}, 32'(m_wr[1]));
        chk("oob0", {31'd0, oob0}, {31'd0, m_oob[0]});
        chk("oob1", {31'd0, oob1}, {31'd0, m_oob[1]});
    endtask

    task automatic set_in(input logic c, input logic w, input logic o,
                          input logic [6:0] a, input logic [31:0] d);
        CEN = c; WEN = w; OEN = o; A = a; D = d;
    endtask

    // Inputs are held from posedge+1; Q sampled at negedge, registers at posedge+1
    task automatic step();
        @(negedge clk);
        chk("q0", q0, m_q(0));
        chk("q1", q1, m_q(1));
        @(posedge clk);
        m_edge();
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_q0", q0, 32'd0);
        chk("rst_q1", q1, 32'd0);
        check_outs();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_step(input int amax);
        logic [6:0] a;
        a = ($urandom_range(1, 0) == 1) ? 7'($urandom_range(amax, 0)) : 7'($urandom_range(127, 0));
        set_in(($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)),
               ($urandom_range(4, 0) == 0), a, $urandom());
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
        do_reset();

        // Full clear with a write attempt at cycle 10 that must be dropped
        for (int i = 0; i < 128; i++) begin
            if (i == 10) set_in(1'b0, 1'b0, 1'b1, 7'd3, 32'h1234);
            else         set_in(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
            step();
        end
        chk("ready_at_128", {31'd0, rdy0}, 32'd1);

        for (int a = 0; a < 128; a++) begin
            set_in(1'b0, 1'b1, 1'b0, 7'(a), $urandom());
            step();
        end

        // Write then read back next cycle
        set_in(1'b0, 1'b0, 1'b0, 7'd5, 32'hDEADBEEF);
        step();
        set_in(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
        @(negedge clk);
        chk("rd_after_wr", q0, 32'hDEADBEEF);
        @(posedge clk);
        m_edge();
        #1;
        check_outs();

        // Gating: OEN high still counts, CEN high does nothing
        set_in(1'b0, 1'b1, 1'b1, 7'd5, 32'd0);
        step();
        set_in(1'b1, 1'b1, 1'b0, 7'd5, 32'd0);
        step();

        for (int i = 0; i < 600; i++) rand_step(15);

        set_in(1'b0, 1'b0, 1'b0, 7'd120, 32'hCAFEF00D);
        step();
        set_in(1'b0, 1'b1, 1'b0, 7'd120, 32'd0);
        step();
        set_in(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
        step();
        chk("oob_sticky1", {31'd0, oob1}, 32'd1);
        chk("rd_sat1", {28'd0, rc1}, 32'd15);

        // Reset 60 cycles into clear, with CPU traffic that must be ignored
        do_reset();
        for (int i = 0; i < 60; i++) rand_step(15);
        do_reset();
        for (int i = 0; i < 128; i++) rand_step(15);
        for (int i = 0; i < 200; i++) rand_step(7);

        // Reset after writes: stored data must read back zero
        do_reset();
        for (int i = 0; i < 128; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
            step();
        end
        for (int a = 0; a < 16; a++) begin
            set_in(1'b0, 1'b1, 1'b0, 7'(a), 32'd0);
            step();
        end
        for (int i = 0; i < 200; i++) rand_step(31);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
